uart_access_arbiter: RTL

- Shares the single UART controller command port between N_REQ requesters, e.g. core load/store unit and boot/debug loader.
- Accepts per-requester ops, grants round-robin, drives the UART enable/instruction/write-value lines one command at a time, captures the write-back data and returns it to the winning requester.
- Adds a blocking-read sequence: polls the RX status until data is available or a timeout expires, then pops one byte.

---
 rtl/uart_arb_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/uart_access_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared op codes, UART instruction codes and arbiter FSM states
package uart_arb_pkg;
    typedef enum logic [1:0] {
        OP_STATUS = 2'b00,
        OP_READ   = 2'b01,
        OP_WRITE  = 2'b10,
        OP_BREAD  = 2'b11
    } op_e;
    localparam logic [2:0] UART_STATUS = 3'b001;
    localparam logic [2:0] UART_READ   = 3'b010;
    localparam logic [2:0] UART_WRITE  = 3'b011;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, POLL_GAP_ST, RESP} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, last accepted winner gets lowest priority
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         init_flag,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int W = N > 1 ? $clog2(N) : 1;
    logic [W-1:0] last, idx;
    // scan requesters starting just after the last winner
    always_comb begin
        grant = '0;
        idx = '0;
        for (int k = 1; k <= N; k++) begin
            idx = W'((int'(last) + k) % N);
            if (req[idx] && grant == '0) grant[idx] = 1'b1;
        end
    end
    // remember the accepted winner; reset makes requester 0 first in line
    always_ff @(posedge clock or negedge init_flag) begin
        if (!init_flag) last <= W'(N - 1);
        else if (advance)
            for (int i = 0; i < N; i++)
                if (grant[i]) last <= W'(i);
    end
endmodule

// File: rtl/uart_access_arbiter.sv
// uart_access_arbiter: shares one UART command port between requesters, with blocking-read polling
module uart_access_arbiter import uart_arb_pkg::*; #(
    parameter int N_REQ        = 2,
    parameter int RESP_LATENCY = 1,
    parameter int POLL_GAP     = 8,
    parameter int POLL_LIMIT   = 255
) (
    input  logic               clock,
    input  logic               init_flag,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [2*N_REQ-1:0] req_op,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   req_grant,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [7:0]         resp_data,
    output logic               resp_timeout,
    output logic               busy,
    output logic               uart_enb,
    output logic [2:0]         uart_instruction,
    output logic [7:0]         uart_write_value,
    input  logic               uart_wb_flag,
    input  logic [7:0]         uart_wb_data
);
    localparam int LW = $clog2(RESP_LATENCY + 1);
    localparam int GW = POLL_GAP > 1 ? $clog2(POLL_GAP + 1) : 1;
    state_e           state;
    op_e              op;
    logic [N_REQ-1:0] grant, sel;
    logic [1:0]       g_op;
    logic [7:0]       g_wd, wdata, rdata, wb;
    logic [LW-1:0]    lat_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [7:0]       poll_cnt;
    logic             rd_phase, tout, adv;
    assign adv = state == IDLE && |req_valid;
    assign wb  = uart_wb_flag ? uart_wb_data : 8'h00;
    rr_arbiter #(.N(N_REQ)) u_rr (
        .clock     (clock),
        .init_flag (init_flag),
        .req       (req_valid),
        .advance   (adv),
        .grant     (grant)
    );
    // pick out the winner's op and write byte
    always_comb begin
        g_op = '0;
        g_wd = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant[i]) begin
                g_op |= req_op[2*i +: 2];
                g_wd |= req_wdata[8*i +: 8];
            end
    end
    // command sequencer; strobes default low so each is a single-cycle pulse
    always_ff @(posedge clock or negedge init_flag) begin
        if (!init_flag) begin
            state            <= IDLE;
            op               <= OP_STATUS;
            sel              <= '0;
            wdata            <= '0;
            rdata            <= '0;
            tout             <= 1'b0;
            rd_phase         <= 1'b0;
            lat_cnt          <= '0;
            gap_cnt          <= '0;
            poll_cnt         <= '0;
            req_grant        <= '0;
            resp_valid       <= '0;
            resp_data        <= '0;
            resp_timeout     <= 1'b0;
            busy             <= 1'b0;
            uart_enb         <= 1'b0;
            uart_instruction <= '0;
            uart_write_value <= '0;
        end else begin
            req_grant        <= '0;
            resp_valid       <= '0;
            resp_data        <= '0;
            resp_timeout     <= 1'b0;
            uart_enb         <= 1'b0;
            uart_instruction <= '0;
            uart_write_value <= '0;
            case (state)
                IDLE: begin
                    busy <= |req_valid;
                    if (|req_valid) begin
                        req_grant <= grant;
                        sel       <= grant;
                        op        <= op_e'(g_op);
                        wdata     <= g_wd;
                        poll_cnt  <= '0;
                        rd_phase  <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    uart_enb         <= 1'b1;
                    uart_instruction <= op == OP_WRITE ? UART_WRITE :
                                        (op == OP_READ || rd_phase) ? UART_READ : UART_STATUS;
                    uart_write_value <= op == OP_WRITE ? wdata : 8'h00;
                    lat_cnt          <= '0;
                    rdata            <= '0;
                    tout             <= 1'b0;
                    state            <= op == OP_WRITE ? RESP : WAIT;
                end
                WAIT: begin
                    if (lat_cnt != LW'(RESP_LATENCY)) lat_cnt <= lat_cnt + 1'b1;
                    else if (op != OP_BREAD || rd_phase) begin
                        rdata <= wb;
                        state <= RESP;
                    end else if (wb[0]) begin
                        rd_phase <= 1'b1;
                        state    <= ISSUE;
                    end else begin
                        poll_cnt <= poll_cnt + 8'd1;
                        gap_cnt  <= '0;
                        tout     <= poll_cnt + 8'd1 == 8'(POLL_LIMIT);
                        state    <= poll_cnt + 8'd1 == 8'(POLL_LIMIT) ? RESP : POLL_GAP_ST;
                    end
                end
                POLL_GAP_ST: begin
                    if (gap_cnt == GW'(POLL_GAP - 1)) state <= ISSUE;
                    else gap_cnt <= gap_cnt + 1'b1;
                end
                RESP: begin
                    resp_valid   <= sel;
                    resp_data    <= rdata;
                    resp_timeout <= tout;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
